pipe_controller: RTL and testbench

PIPE_CONTROLLER -- requirements
Module: pipe_controller

---
 rtl/pipe_ctrl_pkg.sv | 41 ++++
 rtl/pipe_controller_decode.sv | 73 +++++++
 rtl/pipe_controller.sv | 137 +++++++++++++
 tb/tb_pipe_controller.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Package for the pipeline controller: opcode constants, ALUOp encodings,
// the ID/EX control-bit bundle (ctrl_t) and the controller FSM state type.
// No ports; imported by ctrl_decode and pipe_controller.
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_HALT = 7'b0000000;

    localparam logic [1:0] ALUOP_MEM = 2'b00;  // LW/SW/JAL: address add
    localparam logic [1:0] ALUOP_BR  = 2'b01;  // branch compare
    localparam logic [1:0] ALUOP_RI  = 2'b10;  // R/I/JALR: funct-driven
    localparam logic [1:0] ALUOP_LUI = 2'b11;  // LUI: pass immediate

    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jal_to_reg;
        logic       jalr_sel;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_HALTED  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_controller_decode.sv
// ctrl_decode: purely combinational opcode decoder.
// Ports:
//   opcode_i [6:0] - opcode of the instruction in ID
//   ctrl_o         - decoded control bundle (all zero for HALT/unknown)
//   legal_o        - opcode is one of the eight executable instructions
//   halt_o         - opcode is HALT
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output ctrl_t      ctrl_o,
    output logic       legal_o,
    output logic       halt_o
);

    always_comb begin
        ctrl_o  = CTRL_BUBBLE;
        legal_o = 1'b1;
        halt_o  = 1'b0;
        unique case (opcode_i)
            OP_R: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALUOP_RI;
            end
            OP_I: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALUOP_RI;
            end
            OP_LUI: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALUOP_LUI;
            end
            OP_LW: begin
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.alu_op     = ALUOP_MEM;
            end
            OP_SW: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_op    = ALUOP_MEM;
            end
            OP_BR: begin
                ctrl_o.branch = 1'b1;
                ctrl_o.alu_op = ALUOP_BR;
            end
            OP_JAL: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.jal_to_reg = 1'b1;
                ctrl_o.alu_op     = ALUOP_MEM;
            end
            OP_JALR: begin
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.jal_to_reg = 1'b1;
                ctrl_o.jalr_sel   = 1'b1;
                ctrl_o.alu_op     = ALUOP_RI;
            end
            OP_HALT: begin
                legal_o = 1'b0;
                halt_o  = 1'b1;
            end
            default: begin
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pipe_controller.sv
// pipe_controller: ID/EX control register, HALT drain FSM and optional
// load-use hazard detection for a 5-stage in-order pipeline.
// Optional feature: define PIPE_CTRL_LOAD_USE_EN to compile load-use
// stall logic; otherwise stall comes only from DRAIN/HALTED.
// Ports:
//   clk, reset (sync, active-high)
//   Opcode[6:0], id_rs1/id_rs2/id_rd[4:0] - instruction in ID
//   flush       - taken branch/jump in EX, squashes the ID instruction
//   ex_*        - registered ID/EX control bits, ex_ALUOp[1:0], ex_rd[4:0]
//   stall       - combinational freeze of PC and IF/ID
//   halted      - registered, sticky once the pipeline drained after HALT
module pipe_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Opcode,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] id_rd,
    input  logic       flush,
    output logic       ex_ALUSrc,
    output logic       ex_MemtoReg,
    output logic       ex_RegWrite,
    output logic       ex_MemRead,
    output logic       ex_MemWrite,
    output logic       ex_Branch,
    output logic       ex_JaltoReg,
    output logic       ex_JalrSel,
    output logic [1:0] ex_ALUOp,
    output logic [4:0] ex_rd,
    output logic       stall,
    output logic       halted
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [4:0]       rd_q, rd_d;
    logic             halted_q, halted_d;
    logic             stall_c;
    logic             load_use;

    ctrl_t dec_ctrl;
    logic  dec_legal;
    logic  dec_halt;

    ctrl_decode u_decode (
        .opcode_i (Opcode),
        .ctrl_o   (dec_ctrl),
        .legal_o  (dec_legal),
        .halt_o   (dec_halt)
    );

`ifdef PIPE_CTRL_LOAD_USE_EN
    // Load in EX whose destination feeds either source of the ID instruction.
    // x0 never carries a real dependency.
    assign load_use = ctrl_q.mem_read && (rd_q != 5'd0) &&
                      ((rd_q == id_rs1) || (rd_q == id_rs2));
`else
    logic unused_rs;
    assign unused_rs = ^{id_rs1, id_rs2};
    assign load_use  = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        ctrl_d   = CTRL_BUBBLE;
        rd_d     = 5'd0;
        stall_c  = 1'b0;
        halted_d = halted_q | (state_q == ST_HALTED);
        case (state_q)
            ST_RUN: begin
                // flush > load-use > HALT > decode
                if (flush) begin
                    stall_c = 1'b0;
                end else if (load_use) begin
                    stall_c = 1'b1;
                end else if (dec_halt) begin
                    state_d = ST_DRAIN;
                    count_d = CNT_W'(DRAIN_CYCLES);
                end else if (dec_legal) begin
                    ctrl_d = dec_ctrl;
                    rd_d   = id_rd;
                end
            end
            ST_DRAIN: begin
                stall_c = 1'b1;
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                stall_c = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            count_q  <= '0;
            ctrl_q   <= CTRL_BUBBLE;
            rd_q     <= 5'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            ctrl_q   <= ctrl_d;
            rd_q     <= rd_d;
            halted_q <= halted_d;
        end
    end

    assign stall       = stall_c & ~reset;
    assign halted      = halted_q;
    assign ex_ALUSrc   = ctrl_q.alu_src;
    assign ex_MemtoReg = ctrl_q.mem_to_reg;
    assign ex_RegWrite = ctrl_q.reg_write;
    assign ex_MemRead  = ctrl_q.mem_read;
    assign ex_MemWrite = ctrl_q.mem_write;
    assign ex_Branch   = ctrl_q.branch;
    assign ex_JaltoReg = ctrl_q.jal_to_reg;
    assign ex_JalrSel  = ctrl_q.jalr_sel;
    assign ex_ALUOp    = ctrl_q.alu_op;
    assign ex_rd       = rd_q;

endmodule

// File: tb/tb_pipe_controller.sv
module tb_pipe_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] Opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       flush;
    logic       ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead;
    logic       ex_MemWrite, ex_Branch, ex_JaltoReg, ex_JalrSel;
    logic [1:0] ex_ALUOp;
    logic [4:0] ex_rd;
    logic       stall, halted;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_controller #(.DRAIN_CYCLES(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .Opcode      (Opcode),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .flush       (flush),
        .ex_ALUSrc   (ex_ALUSrc),
        .ex_MemtoReg (ex_MemtoReg),
        .ex_RegWrite (ex_RegWrite),
        .ex_MemRead  (ex_MemRead),
        .ex_MemWrite (ex_MemWrite),
        .ex_Branch   (ex_Branch),
        .ex_JaltoReg (ex_JaltoReg),
        .ex_JalrSel  (ex_JalrSel),
        .ex_ALUOp    (ex_ALUOp),
        .ex_rd       (ex_rd),
        .stall       (stall),
        .halted      (halted)
    );

    // Observed ID/EX bundle: {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,JaltoReg,JalrSel,ALUOp,rd}
    logic [14:0] ex_vec;
    assign ex_vec = {ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite,
                     ex_Branch, ex_JaltoReg, ex_JalrSel, ex_ALUOp, ex_rd};

    function automatic logic [14:0] ev(input logic as, input logic m2r, input logic rw,
                                       input logic mr, input logic mw, input logic br,
                                       input logic jr, input logic js, input logic [1:0] op,
                                       input logic [4:0] rd);
        return {as, m2r, rw, mr, mw, br, jr, js, op, rd};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic fl);
        Opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; flush = fl;
    endtask

    initial begin
        reset = 1'b1;
        drive(7'b0110011, 5'd0, 5'd0, 5'd5, 1'b0);
        step();
        step();
        chk("reset_ex", ex_vec, 15'd0);
        chk("reset_stall", stall, 1'b0);
        chk("reset_halted", halted, 1'b0);

        reset = 1'b0;
        drive(7'b0110011, 5'd0, 5'd0, 5'd5, 1'b0); step();
        chk("dec_R", ex_vec, ev(0,0,1,0,0,0,0,0,2'b10,5'd5));
        drive(7'b0010011, 5'd0, 5'd0, 5'd3, 1'b0); step();
        chk("dec_I", ex_vec, ev(1,0,1,0,0,0,0,0,2'b10,5'd3));
        drive(7'b0110111, 5'd0, 5'd0, 5'd9, 1'b0); step();
        chk("dec_LUI", ex_vec, ev(1,0,1,0,0,0,0,0,2'b11,5'd9));
        drive(7'b0000011, 5'd0, 5'd0, 5'd7, 1'b0); step();
        chk("dec_LW", ex_vec, ev(1,1,1,1,0,0,0,0,2'b00,5'd7));
        drive(7'b0100011, 5'd1, 5'd2, 5'd4, 1'b0); #1;
        chk("lw_nodep_stall", stall, 1'b0);
        step();
        chk("dec_SW", ex_vec, ev(1,0,0,0,1,0,0,0,2'b00,5'd4));
        drive(7'b1100011, 5'd0, 5'd0, 5'd6, 1'b0); step();
        chk("dec_BR", ex_vec, ev(0,0,0,0,0,1,0,0,2'b01,5'd6));
        drive(7'b1101111, 5'd0, 5'd0, 5'd1, 1'b0); step();
        chk("dec_JAL", ex_vec, ev(0,0,1,0,0,0,1,0,2'b00,5'd1));
        drive(7'b1100111, 5'd0, 5'd0, 5'd2, 1'b0); step();
        chk("dec_JALR", ex_vec, ev(1,0,1,0,0,0,1,1,2'b10,5'd2));
        drive(7'b1111111, 5'd0, 5'd0, 5'd5, 1'b0); step();
        chk("dec_illegal", ex_vec, 15'd0);

        // flush squashes a normal instruction
        drive(7'b0110011, 5'd0, 5'd0, 5'd5, 1'b1); #1;
        chk("flush_stall", stall, 1'b0);
        step();
        chk("flush_bubble", ex_vec, 15'd0);

        // flush squashes HALT: stays in RUN
        drive(7'b0000000, 5'd0, 5'd0, 5'd0, 1'b1); step();
        chk("flushhalt_ex", ex_vec, 15'd0);
        chk("flushhalt_stall", stall, 1'b0);
        drive(7'b0110011, 5'd0, 5'd0, 5'd5, 1'b0); step();
        chk("flushhalt_run", ex_vec, ev(0,0,1,0,0,0,0,0,2'b10,5'd5));
        chk("flushhalt_stall2", stall, 1'b0);
        step(); step(); step(); step();
        chk("flushhalt_halted", halted, 1'b0);

        // HALT drain: capture edge E0, halted rises on E4
        drive(7'b0000000, 5'd0, 5'd0, 5'd0, 1'b0); step();
        chk("drain_e0_stall", stall, 1'b1);
        chk("drain_e0_ex", ex_vec, 15'd0);
        chk("drain_e0_halted", halted, 1'b0);
        drive(7'b0110011, 5'd0, 5'd0, 5'd5, 1'b1); // flush ignored while draining
        step();
        chk("drain_e1_stall", stall, 1'b1);
        chk("drain_e1_ex", ex_vec, 15'd0);
        chk("drain_e1_halted", halted, 1'b0);
        step();
        chk("drain_e2_halted", halted, 1'b0);
        step();
        chk("drain_e3_halted", halted, 1'b0);
        chk("drain_e3_stall", stall, 1'b1);
        step();
        chk("drain_e4_halted", halted, 1'b1);
        chk("drain_e4_stall", stall, 1'b1);
        chk("drain_e4_ex", ex_vec, 15'd0);
        flush = 1'b0;
        step();
        chk("halted_sticky", halted, 1'b1);

        // reset from HALTED
        reset = 1'b1; #1;
        chk("rst_comb_stall", stall, 1'b0);
        step();
        chk("rst_halted_clr", halted, 1'b0);
        chk("rst_stall_clr", stall, 1'b0);
        reset = 1'b0;
        drive(7'b0110011, 5'd0, 5'd0, 5'd5, 1'b0); step();
        chk("post_rst_run", ex_vec, ev(0,0,1,0,0,0,0,0,2'b10,5'd5));
        chk("post_rst_stall", stall, 1'b0);

        // reset during DRAIN
        drive(7'b0000000, 5'd0, 5'd0, 5'd0, 1'b0); step();
        step();
        chk("mid_drain_stall", stall, 1'b1);
        reset = 1'b1; step();
        reset = 1'b0;
        drive(7'b0010011, 5'd0, 5'd0, 5'd3, 1'b0); #1;
        chk("drain_rst_stall", stall, 1'b0);
        step();
        chk("drain_rst_run", ex_vec, ev(1,0,1,0,0,0,0,0,2'b10,5'd3));

        // load-use: LW x7 followed by consumer of x7
        drive(7'b0000011, 5'd0, 5'd0, 5'd7, 1'b0); step();
        drive(7'b0110011, 5'd1, 5'd7, 5'd8, 1'b0); #1;
`ifdef PIPE_CTRL_LOAD_USE_EN
        chk("lu_stall", stall, 1'b1);
        step();
        chk("lu_bubble", ex_vec, 15'd0);
        chk("lu_stall_clear", stall, 1'b0);
        step();
        chk("lu_issue", ex_vec, ev(0,0,1,0,0,0,0,0,2'b10,5'd8));
`else
        chk("nolu_stall", stall, 1'b0);
        step();
        chk("nolu_issue", ex_vec, ev(0,0,1,0,0,0,0,0,2'b10,5'd8));
`endif
        // LW to x0 never creates a hazard
        drive(7'b0000011, 5'd0, 5'd0, 5'd0, 1'b0); step();
        chk("lw_x0", ex_vec, ev(1,1,1,1,0,0,0,0,2'b00,5'd0));
        drive(7'b0110011, 5'd0, 5'd0, 5'd8, 1'b0); #1;
        chk("lu_x0_stall", stall, 1'b0);
        step();
        chk("lu_x0_issue", ex_vec, ev(0,0,1,0,0,0,0,0,2'b10,5'd8));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
